// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch stage.
package instr_fetch_pkg;

    // Instruction bus address/data width; the fetch stage is built for XLEN = IBUS_AW.
    localparam int unsigned IBUS_AW = 32;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [IBUS_AW-1:0] pc;
        logic [IBUS_AW-1:0] instruction;
    } ifetch_entry_t;

endpackage

// File: rtl/ifetch_skid.sv
// Single-entry holding register for a fetch response that could not enter the output stage.
module ifetch_skid
    import instr_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_b,
    input  logic          load,
    input  logic          clear,
    input  ifetch_entry_t din,
    output logic          valid,
    output ifetch_entry_t dout
);

    logic          valid_q;
    ifetch_entry_t data_q;

    // Occupancy flag; clear wins over load.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            valid_q <= 1'b0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end
    end

    // Payload is only meaningful while valid_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= din;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time on the instruction
// bus and hands pc/instruction pairs to decode over a valid/ready pipeline register.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_b,
    output logic            ibus_req,
    output logic [XLEN-1:0] ibus_addr,
    input  logic            ibus_ready,
    input  logic            ibus_rvalid,
    input  logic [XLEN-1:0] ibus_rdata,
    input  logic            id_pipe_ready,
    input  logic            id_pipe_flush,
    output logic            id_pipe_valid,
    output logic [XLEN-1:0] id_pipe_pc,
    output logic [XLEN-1:0] id_pipe_instruction,
    input  logic            if_redirect,
    input  logic [XLEN-1:0] if_redirect_pc
);

    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

    logic            req_q, req_d;
    logic            outstanding_q, outstanding_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q;
    logic            out_valid_q, out_valid_d;
    ifetch_entry_t   out_q, out_d;

    logic            issue;
    logic            rsp_live;
    logic            out_load;
    logic            skid_valid, skid_valid_next;
    logic            skid_load, skid_clear;
    ifetch_entry_t   skid_dout, rsp_entry;

    // Flush withdraws any pending request so a stale PC never reaches the bus.
    assign ibus_req  = req_q & ~id_pipe_flush;
    assign ibus_addr = pc_q & WORD_MASK;
    assign issue     = ibus_req & ibus_ready;

    // A response is usable only if we asked for it and it belongs to the current path.
    assign rsp_live  = ibus_rvalid & outstanding_q & ~drop_q & ~id_pipe_flush;
    assign out_load  = ~out_valid_q | id_pipe_ready;
    assign rsp_entry = '{pc: resp_pc_q, instruction: ibus_rdata};

    assign skid_load  = rsp_live & ~out_load;
    assign skid_clear = id_pipe_flush | (out_load & skid_valid);

    ifetch_skid u_skid (
        .clk   (clk),
        .rst_b (rst_b),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (rsp_entry),
        .valid (skid_valid),
        .dout  (skid_dout)
    );

    // Bus bookkeeping, PC update and next-request decision.
    always_comb begin
        outstanding_d = outstanding_q;
        if (ibus_rvalid) outstanding_d = 1'b0;
        if (issue)       outstanding_d = 1'b1;

        drop_d = drop_q;
        if (ibus_rvalid) begin
            drop_d = 1'b0;
        end else if (id_pipe_flush && outstanding_q) begin
            drop_d = 1'b1;
        end

        pc_d = pc_q;
        if (id_pipe_flush) begin
            if (if_redirect) pc_d = if_redirect_pc & WORD_MASK;
        end else if (issue) begin
            pc_d = pc_q + WORD_STEP;
        end

        skid_valid_next = skid_clear ? 1'b0 : (skid_load | skid_valid);
        // Request only when nothing is in flight and the skid will be empty, so a returning
        // response always has somewhere to land. A pending unaccepted request satisfies this
        // and therefore stays asserted with a stable address.
        req_d = ~skid_valid_next & ~outstanding_d;
    end

    // Output register: skid entry first, then the live response.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (id_pipe_flush) begin
            out_valid_d = 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                out_valid_d = 1'b1;
                out_d       = skid_dout;
            end else if (rsp_live) begin
                out_valid_d = 1'b1;
                out_d       = rsp_entry;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            req_q         <= 1'b0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            pc_q          <= RESET_PC;
            out_valid_q   <= 1'b0;
        end else begin
            req_q         <= req_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            pc_q          <= pc_d;
            out_valid_q   <= out_valid_d;
        end
    end

    // Data registers, qualified by the valid/outstanding flags above.
    always_ff @(posedge clk) begin
        if (issue) resp_pc_q <= pc_q;
        out_q <= out_d;
    end

    assign id_pipe_valid       = out_valid_q;
    assign id_pipe_pc          = out_q.pc;
    assign id_pipe_instruction = out_q.instruction;

endmodule
